// File: rtl/relu_layer_sequencer.sv
// rtl/relu_layer_sequencer.sv - final-layer ReLU sequencer with streaming output and running arg-max.
// One feature map per start: NUM_ELEMS words in, ReLUed words out, class index reported with done.
module relu_layer_sequencer #(
  parameter int BITWIDTH  = 32,
  parameter int NUM_ELEMS = 10,
  parameter int IDX_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  input  logic                in_valid,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [BITWIDTH-1:0] out_data,
  output logic [IDX_W-1:0]    out_index,
  input  logic                out_ready,
  output logic                done,
  output logic [IDX_W-1:0]    class_idx
);

  // One extra bit so the input counter can sit at NUM_ELEMS without wrapping.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_ELEMS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [BITWIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_index_q, out_index_d;
  logic                done_q, done_d;
  logic [IDX_W-1:0]    class_idx_q, class_idx_d;
  logic [BITWIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0]    max_idx_q, max_idx_d;

  logic                accept;
  logic                consume;
  logic [BITWIDTH-1:0] relu_val;

  assign relu_val = in_data[BITWIDTH-1] ? '0 : in_data;
  assign in_ready = (state_q == RUN) && (in_cnt_q < CNT_MAX) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;
    class_idx_d = class_idx_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          max_d     = '0;
          max_idx_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          out_data_d  = relu_val;
          out_index_d = in_cnt_q[IDX_W-1:0];
          in_cnt_d    = in_cnt_q + CNT_ONE;
          // Strictly greater: ties keep the lower index.
          if (relu_val > max_q) begin
            max_d     = relu_val;
            max_idx_d = in_cnt_q[IDX_W-1:0];
          end
        end
        if (consume) begin
          out_cnt_d = out_cnt_q + CNT_ONE;
        end
        if (accept) begin
          out_valid_d = 1'b1;
        end else if (consume) begin
          out_valid_d = 1'b0;
        end
        if (consume && (out_index_q == LAST_IDX)) begin
          state_d     = DONE;
          done_d      = 1'b1;
          class_idx_d = max_idx_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
      class_idx_q <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
      class_idx_q <= class_idx_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign done      = done_q;
  assign class_idx = class_idx_q;

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// tb/tb_relu_layer_sequencer.sv - directed table-driven bench for relu_layer_sequencer.
module tb_relu_layer_sequencer;
  localparam int BW = 32;
  localparam int N  = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_ready = 1'b0;
  logic          done;
  logic [IW-1:0] class_idx;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0][BW-1:0] din;
    logic [N-1:0][BW-1:0] dout;
    logic [IW-1:0]        cls;
    bit                   bp;
    bit                   start_noise;
  } vec_t;

  vec_t vecs[6];

  relu_layer_sequencer #(.BITWIDTH(BW), .NUM_ELEMS(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_ready(out_ready), .done(done), .class_idx(class_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int k, input int d[N], input int o[N], input int c,
                         input bit bp, input bit sn);
    for (int i = 0; i < N; i++) begin
      vecs[k].din[i]  = d[i];
      vecs[k].dout[i] = o[i];
    end
    vecs[k].cls         = IW'(c);
    vecs[k].bp          = bp;
    vecs[k].start_noise = sn;
  endtask

  // Called at a negedge with the DUT idle; returns one cycle after done, DUT idle again.
  task automatic run_pass(input int k);
    int sent, got, cyc, last_cons;
    bit done_seen, stalled;
    logic [BW-1:0] held_d;
    logic [IW-1:0] held_i;
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = vecs[k].start_noise;
    #1;
    chk("busy_after_start", busy, 1);
    chk("ovalid_after_start", out_valid, 0);
    sent = 0; got = 0; cyc = 0; last_cons = -1;
    done_seen = 0; stalled = 0; held_d = '0; held_i = '0;
    while (!done_seen && cyc < 200) begin
      in_valid  = (sent < N);
      in_data   = (sent < N) ? vecs[k].din[sent] : '0;
      out_ready = vecs[k].bp ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("out_valid", out_valid, (sent > got) ? 1 : 0);
      chk("in_ready", in_ready, ((sent < N) && !(sent > got && !out_ready)) ? 1 : 0);
      if (stalled) begin
        chk("stall_data", out_data, held_d);
        chk("stall_index", out_index, held_i);
      end
      if (done) begin
        done_seen = 1;
        chk("done_latency", cyc, last_cons + 1);
        chk("done_all_out", got, N);
        chk("class_idx", class_idx, vecs[k].cls);
        if (!vecs[k].bp) chk("throughput_cycles", cyc, N + 1);
      end
      if (out_valid && out_ready && got < N) begin
        chk("out_data", out_data, vecs[k].dout[got]);
        chk("out_index", out_index, got);
        got++;
        last_cons = cyc;
      end
      if (in_valid && in_ready) sent++;
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_i  = out_index;
      if (!done_seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done_seen) begin
      n_cmp++; n_bad++;
      $display("FAIL pass_timeout: vector %0d got no done, outputs %0d required %0d", k, got, N);
    end
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("class_idx_held", class_idx, vecs[k].cls);
  endtask

  initial begin
    int got;
    set_vec(0, '{1, 2, 3, -1145, 0, 0, 0, 0, 0, 0}, '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0}, 2, 0, 0);
    set_vec(1, '{1, 2, 3, -1145, 0, 0, 0, 0, 0, 0}, '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0}, 2, 1, 1);
    set_vec(2, '{5, -7, 5, 32'h8000_0000, 4, 0, 0, 0, 0, 0}, '{5, 0, 5, 0, 4, 0, 0, 0, 0, 0}, 0, 0, 0);
    set_vec(3, '{-1, -2, -3, -100, 32'h8000_0000, -5, -6, -7, -8, -9}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 1, 0);
    set_vec(4, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 32'h7fff_ffff}, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 32'h7fff_ffff}, 9, 0, 1);
    set_vec(5, '{3, 9, 2, 9, -4, 1, 9, 0, 8, 7}, '{3, 9, 2, 9, 0, 1, 9, 0, 8, 7}, 1, 1, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 32'd5;
    out_ready = 1'b1;
    #1;
    chk("reset_out_data", out_data, 0);
    chk("reset_out_index", out_index, 0);
    chk("reset_class_idx", class_idx, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle_in_ready", in_ready, 0);
      chk("idle_no_output", out_valid, 0);
      chk("idle_not_busy", busy, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_pass(k);

    // Abort a pass after four outputs with an asynchronous reset.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && got < 4; c++) begin
      in_data = BW'(c + 1);
      #1;
      if (out_valid && out_ready) got++;
      @(negedge clk);
    end
    chk("pre_reset_outputs", got, 4);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_index", out_index, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_class_idx", class_idx, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    run_pass(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
